// File: rtl/lcd_write_sequencer_if.sv
// Byte-write request channel between the MiniAlu LCD opcode and the LCD write sequencer.
// oOverflow is present only when LCD_SEQ_OVERFLOW_EN is defined.
interface lcd_write_sequencer_if;
   logic       iWriteReq;
   logic       iRS;
   logic [7:0] iData;
   logic       oFull;
   logic       oReady;
`ifdef LCD_SEQ_OVERFLOW_EN
   logic       oOverflow;
`endif

   modport master (
      output iWriteReq, iRS, iData,
`ifdef LCD_SEQ_OVERFLOW_EN
      input  oOverflow,
`endif
      input  oFull, oReady
   );

   modport slave (
      input  iWriteReq, iRS, iData,
`ifdef LCD_SEQ_OVERFLOW_EN
      output oOverflow,
`endif
      output oFull, oReady
   );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Queues byte writes and plays them onto a 4-bit character-LCD bus after the power-on init/config sequence.
// Optional sticky drop flag on the interface: define LCD_SEQ_OVERFLOW_EN.
module lcd_write_sequencer #(
   parameter int unsigned FIFO_AW    = 2,
   parameter int unsigned T_POWERUP  = 750000,
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_EHIGH    = 12,
   parameter int unsigned T_NIB_GAP  = 50,
   parameter int unsigned T_CMD_WAIT = 2000,
   parameter int unsigned T_CLR_WAIT = 82000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   lcd_write_sequencer_if.slave  bus,
   output logic                  oLCD_E,
   output logic                  oLCD_RS,
   output logic                  oLCD_RW,
   output logic [3:0]            oLCD_Data,
   output logic                  oLCD_StrataFlashControl
);

   localparam int unsigned CNT_W = 20;
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0]   LD_PWRUP = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0]   LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0]   LD_EHIGH = CNT_W'(T_EHIGH - 1);
   localparam logic [CNT_W-1:0]   LD_GAP   = CNT_W'(T_NIB_GAP - 1);
   localparam logic [CNT_W-1:0]   LD_CMD   = CNT_W'(T_CMD_WAIT - 1);
   localparam logic [CNT_W-1:0]   LD_CLR   = CNT_W'(T_CLR_WAIT - 1);

   typedef enum logic [3:0] {
      PWRUP, INIT_SETUP, INIT_EHI, INIT_WAIT,
      IDLE, SETUP_H, EHI_H, GAP, SETUP_L, EHI_L, WAIT
   } seqState_t;

   function automatic logic [3:0] initNib(input logic [1:0] idx);
      return (idx == 2'd3) ? 4'h2 : 4'h3;
   endfunction

   function automatic logic [7:0] cfgByte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] rstPipe;
   logic       rstN;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) rstPipe <= 2'b00;
      else        rstPipe <= {rstPipe[0], 1'b1};
   end
   assign rstN = rstPipe[1];

   seqState_t        state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       initIdx;
   logic [1:0]       cfgIdx;
   logic             cfgActive;
   logic             shRS;
   logic [7:0]       shByte;
   logic             lcdE;
   logic             lcdRS;
   logic [3:0]       lcdData;
   logic             ready;

   logic [8:0]         fifoMem [DEPTH];
   logic [FIFO_AW-1:0] wrPtr;
   logic [FIFO_AW-1:0] rdPtr;
   logic [FIFO_AW:0]   count;
   logic [FIFO_AW:0]   countNext;
   logic               fullReg;
   logic               pushAcc;
   logic               popNow;
   logic [8:0]         headEntry;
   logic [7:0]         firstCfg;
   logic [7:0]         cfgNextByte;
   logic               slowCmd;
   logic               userTurn;

   assign pushAcc     = bus.iWriteReq && !fullReg;
   assign headEntry   = fifoMem[rdPtr];
   assign firstCfg    = cfgByte(2'd0);
   assign cfgNextByte = cfgByte(cfgIdx + 2'd1);
   assign slowCmd     = !shRS && (shByte <= 8'h03);
   // Once the last config byte is in flight the end of its wait may hand off straight to a queued user byte.
   assign userTurn    = !cfgActive || (cfgIdx == 2'd3);
   assign popNow      = (count != '0) && (cnt == '0) &&
                        ((state == IDLE) || ((state == WAIT) && userTurn));

   always_comb begin
      countNext = count;
      if (pushAcc && !popNow)      countNext = count + 1'b1;
      else if (!pushAcc && popNow) countNext = count - 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (pushAcc) fifoMem[wrPtr] <= {bus.iRS, bus.iData};
   end

   always_ff @(posedge Clock or negedge rstN) begin
      if (!rstN) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         fullReg <= 1'b0;
      end else begin
         if (pushAcc) wrPtr <= wrPtr + 1'b1;
         if (popNow)  rdPtr <= rdPtr + 1'b1;
         count   <= countNext;
         fullReg <= (countNext == FULL_COUNT);
      end
   end

   always_ff @(posedge Clock or negedge rstN) begin
      if (!rstN) begin
         state     <= PWRUP;
         cnt       <= LD_PWRUP;
         initIdx   <= 2'd0;
         cfgIdx    <= 2'd0;
         cfgActive <= 1'b1;
         shRS      <= 1'b0;
         shByte    <= 8'h00;
         lcdE      <= 1'b0;
         lcdRS     <= 1'b0;
         lcdData   <= 4'h0;
         ready     <= 1'b0;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else begin
         unique case (state)
            PWRUP: begin
               state   <= INIT_SETUP;
               cnt     <= LD_SETUP;
               lcdRS   <= 1'b0;
               lcdData <= initNib(initIdx);
            end
            INIT_SETUP: begin
               state <= INIT_EHI;
               cnt   <= LD_EHIGH;
               lcdE  <= 1'b1;
            end
            INIT_EHI: begin
               state <= INIT_WAIT;
               cnt   <= (initIdx == 2'd0) ? LD_CLR : LD_CMD;
               lcdE  <= 1'b0;
            end
            INIT_WAIT: begin
               cnt <= LD_SETUP;
               if (initIdx == 2'd3) begin
                  state   <= SETUP_H;
                  shRS    <= 1'b0;
                  shByte  <= firstCfg;
                  lcdData <= firstCfg[7:4];
               end else begin
                  state   <= INIT_SETUP;
                  initIdx <= initIdx + 2'd1;
                  lcdData <= initNib(initIdx + 2'd1);
               end
            end
            SETUP_H: begin
               state <= EHI_H;
               cnt   <= LD_EHIGH;
               lcdE  <= 1'b1;
            end
            EHI_H: begin
               state <= GAP;
               cnt   <= LD_GAP;
               lcdE  <= 1'b0;
            end
            GAP: begin
               state   <= SETUP_L;
               cnt     <= LD_SETUP;
               lcdData <= shByte[3:0];
            end
            SETUP_L: begin
               state <= EHI_L;
               cnt   <= LD_EHIGH;
               lcdE  <= 1'b1;
            end
            EHI_L: begin
               state <= WAIT;
               cnt   <= slowCmd ? LD_CLR : LD_CMD;
               lcdE  <= 1'b0;
            end
            WAIT: begin
               if (!userTurn) begin
                  state   <= SETUP_H;
                  cnt     <= LD_SETUP;
                  cfgIdx  <= cfgIdx + 2'd1;
                  shRS    <= 1'b0;
                  shByte  <= cfgNextByte;
                  lcdRS   <= 1'b0;
                  lcdData <= cfgNextByte[7:4];
               end else begin
                  cfgActive <= 1'b0;
                  ready     <= 1'b1;
                  if (popNow) begin
                     state   <= SETUP_H;
                     cnt     <= LD_SETUP;
                     shRS    <= headEntry[8];
                     shByte  <= headEntry[7:0];
                     lcdRS   <= headEntry[8];
                     lcdData <= headEntry[7:4];
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            IDLE: begin
               if (popNow) begin
                  state   <= SETUP_H;
                  cnt     <= LD_SETUP;
                  shRS    <= headEntry[8];
                  shByte  <= headEntry[7:0];
                  lcdRS   <= headEntry[8];
                  lcdData <= headEntry[7:4];
               end
            end
            default: begin
               state <= PWRUP;
               cnt   <= LD_PWRUP;
               lcdE  <= 1'b0;
            end
         endcase
      end
   end

`ifdef LCD_SEQ_OVERFLOW_EN
   logic overflow;

   always_ff @(posedge Clock or negedge rstN) begin
      if (!rstN)                            overflow <= 1'b0;
      else if (bus.iWriteReq && fullReg)    overflow <= 1'b1;
   end
   assign bus.oOverflow = overflow;
`endif

   assign bus.oFull               = fullReg;
   assign bus.oReady              = ready;
   assign oLCD_E                  = lcdE;
   assign oLCD_RS                 = lcdRS;
   assign oLCD_Data               = lcdData;
   assign oLCD_RW                 = 1'b0;
   assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing; a monitor logs every E pulse.
module tb_lcd_write_sequencer;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       lcdE, lcdRS, lcdRW, lcdSF;
   logic [3:0] lcdData;

   lcd_write_sequencer_if bus();

   lcd_write_sequencer #(
      .FIFO_AW(2), .T_POWERUP(20), .T_SETUP(2), .T_EHIGH(3),
      .T_NIB_GAP(4), .T_CMD_WAIT(10), .T_CLR_WAIT(30)
   ) dut (
      .Clock(clk),
      .Reset(Reset),
      .bus(bus),
      .oLCD_E(lcdE),
      .oLCD_RS(lcdRS),
      .oLCD_RW(lcdRW),
      .oLCD_Data(lcdData),
      .oLCD_StrataFlashControl(lcdSF)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nib;
      int rs;
      int rise;
      int len;
      int fall;
   } pulse_t;

   pulse_t pulses[$];
   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   int     readyCyc = -1;
   logic   prevE = 1'b0;
   logic   prevReady = 1'b0;
   int     riseCyc = 0, riseNib = 0, riseRs = 0;

   // Timestamps are negedge counts; rise/fall are the first cycles with E high/low.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (lcdE && !prevE) begin
         riseCyc = cyc;
         riseNib = int'(lcdData);
         riseRs  = int'(lcdRS);
      end
      if (!lcdE && prevE)
         pulses.push_back('{riseNib, riseRs, riseCyc, cyc - riseCyc, cyc});
      if (bus.oReady && !prevReady) readyCyc = cyc;
      prevE     = lcdE;
      prevReady = bus.oReady;
   end

   task automatic checkVal(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drivePush(input logic rs, input logic [7:0] data);
      bus.iWriteReq = 1'b1;
      bus.iRS       = rs;
      bus.iData     = data;
      @(negedge clk);
      $display("push rs=%0d data=%02h full=%0d", rs, data, bus.oFull);
   endtask

   task automatic driveIdle();
      bus.iWriteReq = 1'b0;
      bus.iRS       = 1'b0;
      bus.iData     = 8'h00;
   endtask

   task automatic waitPulses(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (pulses.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkVal({tag, "_pulseCount"}, (pulses.size() >= n) ? n : pulses.size(), n);
   endtask

   // Byte i of an n-byte list sits at bits [8*(n-1-i) +: 8].
   task automatic expectBytes(input string tag, input int start, input logic [63:0] bytes,
                              input int n, input int rsv);
      logic [7:0] b;
      pulse_t     hi, lo;
      for (int i = 0; i < n; i++) begin
         b  = bytes[8*(n-1-i) +: 8];
         hi = pulses[start + 2*i];
         lo = pulses[start + 2*i + 1];
         $display("%s byte %0d: rs=%0d hi=%h lo=%h", tag, i, hi.rs, hi.nib, lo.nib);
         checkVal($sformatf("%s_b%0d_hiNib", tag, i), hi.nib, int'(b[7:4]));
         checkVal($sformatf("%s_b%0d_loNib", tag, i), lo.nib, int'(b[3:0]));
         checkVal($sformatf("%s_b%0d_hiRs", tag, i), hi.rs, rsv);
         checkVal($sformatf("%s_b%0d_loRs", tag, i), lo.rs, rsv);
         checkVal($sformatf("%s_b%0d_hiLen", tag, i), hi.len, 3);
         checkVal($sformatf("%s_b%0d_loLen", tag, i), lo.len, 3);
         checkVal($sformatf("%s_b%0d_nibGap", tag, i), lo.rise - hi.fall, 6);
      end
   endtask

   task automatic expectInit(input string tag);
      logic [15:0] initNibs;
      initNibs = 16'h3332;
      for (int i = 0; i < 4; i++) begin
         $display("%s init nibble %0d: %h len=%0d", tag, i, pulses[i].nib, pulses[i].len);
         checkVal($sformatf("%s_init%0d_nib", tag, i), pulses[i].nib, int'(initNibs[4*(3-i) +: 4]));
         checkVal($sformatf("%s_init%0d_rs", tag, i), pulses[i].rs, 0);
         checkVal($sformatf("%s_init%0d_len", tag, i), pulses[i].len, 3);
      end
      checkVal({tag, "_initClrGap"}, pulses[1].rise - pulses[0].fall, 32);
      checkVal({tag, "_initCmdGap"}, pulses[2].rise - pulses[1].fall, 12);
      checkVal({tag, "_cfgEntryGap"}, pulses[4].rise - pulses[3].fall, 12);
      expectBytes({tag, "_cfg"}, 4, {8'h28, 8'h06, 8'h0C, 8'h01}, 4, 0);
   endtask

   task automatic expectReady(input string tag);
      int k;
      k = 0;
      while (!bus.oReady && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      checkVal({tag, "_ready"}, int'(bus.oReady), 1);
      checkVal({tag, "_readyDelay"}, readyCyc - pulses[11].fall, 30);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [5:0] fillFull;
      logic [4:0] pwrFull;
      fillFull = 6'b000011;
      pwrFull  = 5'b00011;
      driveIdle();

      // Reset state
      #1 Reset = 1'b0;
      repeat (3) @(negedge clk);
      checkVal("rst_E", int'(lcdE), 0);
      checkVal("rst_RS", int'(lcdRS), 0);
      checkVal("rst_Data", int'(lcdData), 0);
      checkVal("rst_RW", int'(lcdRW), 0);
      checkVal("rst_SF", int'(lcdSF), 1);
      checkVal("rst_ready", int'(bus.oReady), 0);
      checkVal("rst_full", int'(bus.oFull), 0);
      Reset = 1'b1;

      // Test 1: autonomous init + config
      waitPulses("t1", 12, 2000);
      expectInit("t1");
      expectReady("t1");
      pulses.delete();

      // Test 2: two data bytes back to back
      drivePush(1'b1, 8'h41);
      drivePush(1'b1, 8'h43);
      driveIdle();
      waitPulses("t2", 4, 400);
      expectBytes("t2", 0, {8'h41, 8'h43}, 2, 1);
      checkVal("t2_byteGap", pulses[2].rise - pulses[1].fall, 12);
      repeat (20) @(negedge clk);
      pulses.delete();

      // Test 3: fill the FIFO while the sequencer is busy with the first byte
`ifdef LCD_SEQ_OVERFLOW_EN
      checkVal("t3_ovfBefore", int'(bus.oOverflow), 0);
`endif
      for (int i = 0; i < 6; i++) begin
         drivePush(1'b1, 8'h50 + 8'(i));
         checkVal($sformatf("t3_full%0d", i), int'(bus.oFull), int'(fillFull[5-i]));
      end
      driveIdle();
`ifdef LCD_SEQ_OVERFLOW_EN
      checkVal("t3_ovfAfter", int'(bus.oOverflow), 1);
`endif
      waitPulses("t3", 10, 1000);
      expectBytes("t3", 0, {8'h50, 8'h51, 8'h52, 8'h53, 8'h54}, 5, 1);
      repeat (60) @(negedge clk);
      checkVal("t3_noExtra", pulses.size(), 10);
      checkVal("t3_fullClear", int'(bus.oFull), 0);
      pulses.delete();

      // Test 4: clear command then data; the slow wait governs the spacing
      drivePush(1'b0, 8'h01);
      drivePush(1'b1, 8'h42);
      driveIdle();
      waitPulses("t4", 4, 500);
      expectBytes("t4_cmd", 0, {8'h01}, 1, 0);
      expectBytes("t4_dat", 2, {8'h42}, 1, 1);
      checkVal("t4_clrGap", pulses[2].rise - pulses[1].fall, 32);
      repeat (20) @(negedge clk);
      pulses.delete();

      // Test 5: reset in the middle of a high-nibble pulse
      drivePush(1'b1, 8'h61);
      drivePush(1'b1, 8'h62);
      driveIdle();
      k = 0;
      while (!lcdE && k < 50) begin
         @(negedge clk);
         k++;
      end
      checkVal("t5_eHighBeforeReset", int'(lcdE), 1);
      #2 Reset = 1'b0;
      #1;
      checkVal("t5_eAsync", int'(lcdE), 0);
      checkVal("t5_rsAsync", int'(lcdRS), 0);
      checkVal("t5_dataAsync", int'(lcdData), 0);
      checkVal("t5_fullAsync", int'(bus.oFull), 0);
      checkVal("t5_readyAsync", int'(bus.oReady), 0);
`ifdef LCD_SEQ_OVERFLOW_EN
      checkVal("t5_ovfAsync", int'(bus.oOverflow), 0);
`endif
      repeat (3) @(negedge clk);
      Reset = 1'b1;
      repeat (4) @(negedge clk);
      pulses.delete();
      readyCyc = -1;
      for (int i = 0; i < 5; i++) begin
         drivePush(1'b1, 8'h70 + 8'(i));
         checkVal($sformatf("t5_full%0d", i), int'(bus.oFull), int'(pwrFull[4-i]));
      end
      driveIdle();
`ifdef LCD_SEQ_OVERFLOW_EN
      checkVal("t5_ovfAfter", int'(bus.oOverflow), 1);
`endif
      waitPulses("t5", 20, 2000);
      expectInit("t5");
      expectBytes("t5_user", 12, {8'h70, 8'h71, 8'h72, 8'h73}, 4, 1);
      checkVal("t5_readyDelay", readyCyc - pulses[11].fall, 30);
      repeat (60) @(negedge clk);
      checkVal("t5_noExtra", pulses.size(), 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
